sn_bitstream_counter: RTL and testbench
=======================================

SN_BITSTREAM_COUNTER -- requirements
Module: sn_bitstream_counter

Interface
REQ-001 SHALL have parameter: CNT_W, default 7, width of the count and result; must be >= 7.
REQ-002 SHALL have port: clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port: rst_n  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port: sn_bit  input  1  stochastic bit from the upstream multiplier.
REQ-005 SHALL have port: sn_valid  input  1  sn_bit qualifier; a bit is accepted only when high.
REQ-006 SHALL have port: win_sel  input  2  window length N = 2^(win_sel+3), i.e. 8/16/32/64.
REQ-007 SHALL have port: start  input  1  request to begin a new counting window.
REQ-008 SHALL have port: prob_out  output  CNT_W  number of ones counted in the last window.
REQ-009 SHALL have port: prob_valid  output  1  prob_out holds a completed result.
REQ-010 SHALL have port: prob_ready  input  1  consumer accepts the result when high with prob_valid.
REQ-011 SHALL have port: busy  output  1  high while in COUNT.
REQ-012 SHALL have port: dropped  output  1  sticky flag: a valid bit arrived while not counting.

Function
REQ-013 SHALL implement an FSM with states IDLE, COUNT, DONE.
REQ-014 In IDLE, start=1 SHALL latch win_sel, clear the ones and sample counters, and enter COUNT next cycle.
REQ-015 In COUNT, each cycle with sn_valid=1 SHALL increment the sample counter and add sn_bit to the ones counter; with sn_valid=0 both hold.
REQ-016 When the accepted sample is the N-th, SHALL load prob_out with the final count including that bit, assert prob_valid, and enter DONE; latency is one cycle from the last accepted bit.
REQ-017 All-ones window SHALL yield prob_out = N (64 max, no wrap); all-zeros SHALL yield 0.
REQ-018 In DONE, prob_out and prob_valid SHALL hold stable until prob_valid && prob_ready.
REQ-019 On handshake with start=0 SHALL go to IDLE and deassert prob_valid next cycle.
REQ-020 On handshake with start=1 in the same cycle SHALL go directly to COUNT with a freshly latched win_sel (back-to-back windows).
REQ-021 start in COUNT and win_sel changes after latch SHALL be ignored.
REQ-022 sn_valid=1 in IDLE or DONE SHALL discard the bit and set dropped; dropped SHALL clear only when a new window starts.
REQ-023 busy SHALL be high exactly while the state is COUNT.

Reset
REQ-024 rst_n low SHALL immediately force IDLE and set prob_out=0, prob_valid=0, busy=0, dropped=0, counters=0, latched window=8.
REQ-025 Reset asserted mid-window SHALL discard the partial count; no result is produced for that window.

Configuration
REQ-026 With macro SN_BIPOLAR_OUT_EN defined, SHALL add output bipolar_out (signed, CNT_W+1 bits) = 2*prob_out - N, registered and valid with prob_valid, reset 0.
REQ-027 Without SN_BIPOLAR_OUT_EN, bipolar_out and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package sn_pkg SHALL hold the FSM state enum, the win_sel-to-N mapping constants, and CNT_W default.
REQ-029 SHALL be a single module; no sub-module is warranted.

Verification
REQ-030 win_sel=0, start, 8 valid ones -> prob_valid one cycle after 8th bit, prob_out=8.
REQ-031 win_sel=3, 64 bits alternating 1/0 with sn_valid gaps every 3rd cycle -> prob_out=32, busy high throughout COUNT.
REQ-032 Result pending, prob_ready low 5 cycles, sn_valid=1 -> prob_out stable, dropped=1; then prob_ready+start same cycle -> COUNT next cycle, dropped=0.
REQ-033 rst_n low after 20 of 32 bits -> all outputs 0 asynchronously, IDLE; new window counts from 0.
REQ-034 SN_BIPOLAR_OUT_EN defined, window 16: 16 ones -> bipolar_out=+16; 0 ones -> -16; 8 ones -> 0.

Source files
------------

// File: rtl/sn_bitstream_counter_pkg.sv
// Shared types and constants for the stochastic bitstream counter:
// FSM state encoding, window-length mapping and the default count width.
package sn_pkg;

   localparam int SN_CNT_W_DEF = 7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_COUNT = 2'd1,
      ST_DONE  = 2'd2
   } sn_state_e;

   localparam logic [1:0] SN_WIN_SEL_RST = 2'd0;
   localparam logic [6:0] SN_N_8  = 7'd8;
   localparam logic [6:0] SN_N_16 = 7'd16;
   localparam logic [6:0] SN_N_32 = 7'd32;
   localparam logic [6:0] SN_N_64 = 7'd64;

   // Window length N = 2^(win_sel+3)
   function automatic logic [6:0] sn_win_len(input logic [1:0] ws);
      case (ws)
         2'd0:    return SN_N_8;
         2'd1:    return SN_N_16;
         2'd2:    return SN_N_32;
         2'd3:    return SN_N_64;
         default: return SN_N_8;
      endcase
   endfunction

endpackage

// File: rtl/sn_bitstream_counter.sv
// Counts ones in a window of 8/16/32/64 qualified stochastic bits and hands the
// result over a valid/ready handshake. Optional signed output under SN_BIPOLAR_OUT_EN.
module sn_bitstream_counter
   import sn_pkg::*;
#(
   parameter int CNT_W = SN_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sn_bit,
   input  logic             sn_valid,
   input  logic [1:0]       win_sel,
   input  logic             start,
   output logic [CNT_W-1:0] prob_out,
   output logic             prob_valid,
   input  logic             prob_ready,
   output logic             busy,
   output logic             dropped
`ifdef SN_BIPOLAR_OUT_EN
   ,
   output logic signed [CNT_W:0] bipolar_out
`endif
);

   sn_state_e        state_r, state_nxt_s;
   logic [1:0]       win_sel_r, win_sel_nxt_s;
   logic [CNT_W-1:0] samp_cnt_r, samp_cnt_nxt_s;
   logic [CNT_W-1:0] ones_cnt_r, ones_cnt_nxt_s;
   logic [CNT_W-1:0] prob_out_r, prob_out_nxt_s;
   logic             prob_valid_r, prob_valid_nxt_s;
   logic             busy_r, busy_nxt_s;
   logic             dropped_r, dropped_nxt_s;
   logic [CNT_W-1:0] n_s, samp_inc_s, ones_inc_s;
   logic             last_s, hs_s, start_win_s;
`ifdef SN_BIPOLAR_OUT_EN
   logic signed [CNT_W:0] bipolar_r, bipolar_nxt_s;
`endif

   assign n_s         = CNT_W'(sn_win_len(win_sel_r));
   assign samp_inc_s  = samp_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   assign ones_inc_s  = ones_cnt_r + {{(CNT_W-1){1'b0}}, sn_bit};
   assign last_s      = (samp_inc_s == n_s);
   assign hs_s        = prob_valid_r & prob_ready;
   // A new window opens from IDLE, or straight out of DONE on a same-cycle handshake
   assign start_win_s = start & ((state_r == ST_IDLE) | ((state_r == ST_DONE) & hs_s));

   // Next-state logic
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start) state_nxt_s = ST_COUNT;
            else       state_nxt_s = ST_IDLE;
         end
         ST_COUNT: begin
            if (sn_valid && last_s) state_nxt_s = ST_DONE;
            else                    state_nxt_s = ST_COUNT;
         end
         ST_DONE: begin
            if (hs_s) state_nxt_s = start ? ST_COUNT : ST_IDLE;
            else      state_nxt_s = ST_DONE;
         end
         default: state_nxt_s = ST_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      win_sel_nxt_s    = win_sel_r;
      samp_cnt_nxt_s   = samp_cnt_r;
      ones_cnt_nxt_s   = ones_cnt_r;
      prob_out_nxt_s   = prob_out_r;
      prob_valid_nxt_s = prob_valid_r;
      dropped_nxt_s    = dropped_r;
`ifdef SN_BIPOLAR_OUT_EN
      bipolar_nxt_s    = bipolar_r;
`endif
      if (start_win_s) begin
         win_sel_nxt_s  = win_sel;
         samp_cnt_nxt_s = {CNT_W{1'b0}};
         ones_cnt_nxt_s = {CNT_W{1'b0}};
         dropped_nxt_s  = 1'b0;
      end else if (state_r == ST_COUNT && sn_valid) begin
         samp_cnt_nxt_s = samp_inc_s;
         ones_cnt_nxt_s = ones_inc_s;
         if (last_s) begin
            prob_out_nxt_s   = ones_inc_s;
            prob_valid_nxt_s = 1'b1;
`ifdef SN_BIPOLAR_OUT_EN
            bipolar_nxt_s    = $signed({ones_inc_s, 1'b0}) - $signed({1'b0, n_s});
`endif
         end else begin
            prob_valid_nxt_s = prob_valid_r;
         end
      end else if (state_r != ST_COUNT && sn_valid) begin
         dropped_nxt_s = 1'b1;
      end else begin
         dropped_nxt_s = dropped_r;
      end
      if (state_r == ST_DONE && hs_s) prob_valid_nxt_s = 1'b0;
      else                            prob_valid_nxt_s = prob_valid_nxt_s;
      busy_nxt_s = (state_nxt_s == ST_COUNT);
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_r <= ST_IDLE;
      else        state_r <= state_nxt_s;
   end

   // Datapath and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_sel_r    <= SN_WIN_SEL_RST;
         samp_cnt_r   <= {CNT_W{1'b0}};
         ones_cnt_r   <= {CNT_W{1'b0}};
         prob_out_r   <= {CNT_W{1'b0}};
         prob_valid_r <= 1'b0;
         busy_r       <= 1'b0;
         dropped_r    <= 1'b0;
`ifdef SN_BIPOLAR_OUT_EN
         bipolar_r    <= {(CNT_W+1){1'b0}};
`endif
      end else begin
         win_sel_r    <= win_sel_nxt_s;
         samp_cnt_r   <= samp_cnt_nxt_s;
         ones_cnt_r   <= ones_cnt_nxt_s;
         prob_out_r   <= prob_out_nxt_s;
         prob_valid_r <= prob_valid_nxt_s;
         busy_r       <= busy_nxt_s;
         dropped_r    <= dropped_nxt_s;
`ifdef SN_BIPOLAR_OUT_EN
         bipolar_r    <= bipolar_nxt_s;
`endif
      end
   end

   assign prob_out   = prob_out_r;
   assign prob_valid = prob_valid_r;
   assign busy       = busy_r;
   assign dropped    = dropped_r;
`ifdef SN_BIPOLAR_OUT_EN
   assign bipolar_out = bipolar_r;
`endif

endmodule

// File: tb/tb_sn_bitstream_counter.sv
// Directed self-checking bench for sn_bitstream_counter; bipolar checks only
// when SN_BIPOLAR_OUT_EN is defined.
module tb_sn_bitstream_counter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       sn_bit = 1'b0;
   logic       sn_valid = 1'b0;
   logic [1:0] win_sel = 2'd0;
   logic       start = 1'b0;
   logic [6:0] prob_out;
   logic       prob_valid;
   logic       prob_ready = 1'b0;
   logic       busy;
   logic       dropped;
`ifdef SN_BIPOLAR_OUT_EN
   logic signed [7:0] bipolar_out;
`endif

   int tests = 0;
   int fails = 0;

   sn_bitstream_counter #(.CNT_W(7)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .sn_bit     (sn_bit),
      .sn_valid   (sn_valid),
      .win_sel    (win_sel),
      .start      (start),
      .prob_out   (prob_out),
      .prob_valid (prob_valid),
      .prob_ready (prob_ready),
      .busy       (busy),
      .dropped    (dropped)
`ifdef SN_BIPOLAR_OUT_EN
      ,
      .bipolar_out(bipolar_out)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic run_window(input logic [1:0] ws, input logic [63:0] pat);
      int n;
      n = 8 << ws;
      win_sel = ws;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         sn_valid = 1'b1;
         sn_bit   = pat[i];
         cyc();
      end
      sn_valid = 1'b0;
      sn_bit   = 1'b0;
   endtask

   task automatic consume();
      prob_ready = 1'b1;
      cyc();
      prob_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cyc();
      cyc();
      tests++;
      if ({prob_out, prob_valid, busy, dropped} !== 10'd0) begin
         fails++;
         $display("FAIL reset_outs: got %h expected 0", {prob_out, prob_valid, busy, dropped});
      end
`ifdef SN_BIPOLAR_OUT_EN
      tests++;
      if (bipolar_out !== 8'sd0) begin
         fails++;
         $display("FAIL reset_bipolar: got %0d expected 0", bipolar_out);
      end
`endif
      rst_n = 1'b1;
      cyc();
   endtask

   task automatic test_win8();
      win_sel = 2'd0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      tests++;
      if (busy !== 1'b1) begin
         fails++;
         $display("FAIL win8_busy: got %b expected 1", busy);
      end
      sn_valid = 1'b1;
      sn_bit = 1'b1;
      for (int i = 0; i < 8; i++) begin
         cyc();
         if (i == 6) begin
            tests++;
            if (prob_valid !== 1'b0) begin
               fails++;
               $display("FAIL win8_early: got %b expected 0", prob_valid);
            end
         end
      end
      sn_valid = 1'b0;
      sn_bit = 1'b0;
      tests++;
      if (prob_valid !== 1'b1 || prob_out !== 7'd8 || busy !== 1'b0) begin
         fails++;
         $display("FAIL win8_result: got v=%b out=%0d busy=%b expected v=1 out=8 busy=0",
                  prob_valid, prob_out, busy);
      end
      consume();
      tests++;
      if (prob_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL win8_release: got v=%b busy=%b expected v=0 busy=0", prob_valid, busy);
      end
   endtask

   task automatic test_alt64();
      int acc, c;
      logic busy_bad;
      acc = 0;
      c = 0;
      busy_bad = 1'b0;
      win_sel = 2'd3;
      start = 1'b1;
      cyc();
      // start held and win_sel changed while counting: both must be ignored
      win_sel = 2'd0;
      while (acc < 64 && c < 200) begin
         sn_valid = (c % 3 != 2);
         sn_bit   = (acc % 2 == 0);
         cyc();
         if (sn_valid) acc++;
         c++;
         if (acc < 64 && busy !== 1'b1) busy_bad = 1'b1;
      end
      start = 1'b0;
      sn_valid = 1'b0;
      sn_bit = 1'b0;
      tests++;
      if (busy_bad !== 1'b0 || acc != 64) begin
         fails++;
         $display("FAIL alt64_busy: got busy_bad=%b acc=%0d expected 0 64", busy_bad, acc);
      end
      tests++;
      if (prob_valid !== 1'b1 || prob_out !== 7'd32 || dropped !== 1'b0) begin
         fails++;
         $display("FAIL alt64_result: got v=%b out=%0d drop=%b expected v=1 out=32 drop=0",
                  prob_valid, prob_out, dropped);
      end
      consume();
   endtask

   task automatic test_all_zeros();
      run_window(2'd1, 64'h0);
      tests++;
      if (prob_valid !== 1'b1 || prob_out !== 7'd0) begin
         fails++;
         $display("FAIL zeros16: got v=%b out=%0d expected v=1 out=0", prob_valid, prob_out);
      end
      consume();
   endtask

   task automatic test_back_to_back();
      logic stable_bad;
      stable_bad = 1'b0;
      run_window(2'd0, 64'h4D);
      sn_valid = 1'b1;
      sn_bit = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cyc();
         if (prob_out !== 7'd4 || prob_valid !== 1'b1) stable_bad = 1'b1;
      end
      sn_valid = 1'b0;
      sn_bit = 1'b0;
      tests++;
      if (stable_bad !== 1'b0) begin
         fails++;
         $display("FAIL hold_stable: got out=%0d v=%b expected out=4 v=1", prob_out, prob_valid);
      end
      tests++;
      if (dropped !== 1'b1) begin
         fails++;
         $display("FAIL dropped_set: got %b expected 1", dropped);
      end
      prob_ready = 1'b1;
      start = 1'b1;
      win_sel = 2'd1;
      cyc();
      prob_ready = 1'b0;
      start = 1'b0;
      tests++;
      if (busy !== 1'b1 || dropped !== 1'b0 || prob_valid !== 1'b0) begin
         fails++;
         $display("FAIL b2b_start: got busy=%b drop=%b v=%b expected 1 0 0",
                  busy, dropped, prob_valid);
      end
      for (int i = 0; i < 16; i++) begin
         sn_valid = 1'b1;
         sn_bit = (i < 5);
         cyc();
      end
      sn_valid = 1'b0;
      sn_bit = 1'b0;
      tests++;
      if (prob_valid !== 1'b1 || prob_out !== 7'd5) begin
         fails++;
         $display("FAIL b2b_result: got v=%b out=%0d expected v=1 out=5", prob_valid, prob_out);
      end
      consume();
   endtask

   task automatic test_reset_mid();
      win_sel = 2'd2;
      start = 1'b1;
      cyc();
      start = 1'b0;
      for (int i = 0; i < 20; i++) begin
         sn_valid = 1'b1;
         sn_bit = 1'b1;
         cyc();
      end
      sn_valid = 1'b0;
      sn_bit = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      tests++;
      if (busy !== 1'b0 || prob_out !== 7'd0 || prob_valid !== 1'b0 || dropped !== 1'b0) begin
         fails++;
         $display("FAIL async_reset: got busy=%b out=%0d v=%b drop=%b expected all 0",
                  busy, prob_out, prob_valid, dropped);
      end
      cyc();
      rst_n = 1'b1;
      cyc();
      cyc();
      tests++;
      if (prob_valid !== 1'b0 || busy !== 1'b0) begin
         fails++;
         $display("FAIL post_reset_idle: got v=%b busy=%b expected 0 0", prob_valid, busy);
      end
      run_window(2'd0, 64'h07);
      tests++;
      if (prob_valid !== 1'b1 || prob_out !== 7'd3) begin
         fails++;
         $display("FAIL post_reset_window: got v=%b out=%0d expected v=1 out=3",
                  prob_valid, prob_out);
      end
      consume();
   endtask

`ifdef SN_BIPOLAR_OUT_EN
   task automatic test_bipolar();
      run_window(2'd1, 64'hFFFF);
      tests++;
      if (bipolar_out !== 8'sd16 || prob_out !== 7'd16) begin
         fails++;
         $display("FAIL bipolar_p16: got %0d expected 16", bipolar_out);
      end
      consume();
      run_window(2'd1, 64'h0);
      tests++;
      if (bipolar_out !== -8'sd16) begin
         fails++;
         $display("FAIL bipolar_m16: got %0d expected -16", bipolar_out);
      end
      consume();
      run_window(2'd1, 64'h00FF);
      tests++;
      if (bipolar_out !== 8'sd0 || prob_valid !== 1'b1) begin
         fails++;
         $display("FAIL bipolar_zero: got %0d expected 0", bipolar_out);
      end
      consume();
   endtask
`endif

   initial begin
      test_reset();
      test_win8();
      test_alt64();
      test_all_zeros();
      test_back_to_back();
      test_reset_mid();
`ifdef SN_BIPOLAR_OUT_EN
      test_bipolar();
`endif
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
